mcycle_sequencer: RTL
=====================

Name: mcycle_sequencer

Overview:
- Multi-cycle control FSM for the 32-bit processor.
- Fetches instructions over a req/ack instruction-memory port and holds them in an instruction register (IR) that feeds the combinational instruction decoder.
- Steps each instruction through DECODE/EXEC/MEM/WB and gates register-file and data-memory strobes to one cycle each.
- Sits between the instruction/data memories and the decoder, register file and ALU datapath.

Parameters:
- DWIDTH, 32: instruction and data word width.
- AWIDTH, 16: program counter width; PC is a word address.
- TIMEOUT, 255: maximum wait cycles for a memory ack before FAULT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  enables fetching of the next instruction.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AWIDTH  fetch address; equals pc.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  DWIDTH  fetched instruction word.
- ir  out  DWIDTH  instruction register; drives the decoder.
- pc  out  AWIDTH  program counter.
- dmem_req  out  1  data memory access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- alu_en  out  1  ALU result capture strobe.
- rf_we  out  1  register-file write strobe.
- busy  out  1  high in every state except IDLE and FAULT.
- fault  out  1  sticky memory-timeout flag.
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; pc=0; ir=0; retired=0; wait counter=0; all strobes and fault=0. Reset mid-transaction abandons it immediately; no strobe is asserted in the cycle after rst.
- Opcode field is ir[18:15]. Fixed encodings: NOP=4'b1111, LOAD=4'b0100, STORE=4'b0110. All other opcodes are ALU class.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH: imem_req=1 and imem_addr=pc. On imem_ack: ir<=imem_rdata, pc<=pc+1 (wraps modulo 2^AWIDTH), go to DECODE.
- DECODE: one cycle, no strobes.
  - NOP: retired++, then FETCH if run=1 else IDLE.
  - Otherwise: go to EXEC.
- EXEC: alu_en=1 for exactly one cycle.
  - LOAD or STORE: go to MEM.
  - Otherwise: go to WB.
- MEM: dmem_req=1 and dmem_we=(opcode==STORE). On dmem_ack:
  - LOAD: go to WB.
  - STORE: retired++, then FETCH if run=1 else IDLE.
- WB: rf_we=1 for one cycle, retired++, then FETCH if run=1 else IDLE.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU instruction: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - NOP: 2 cycles.
- Wait counter: 8 bits.
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle the request is held without an ack.
  - When the counter equals TIMEOUT and no ack arrives: go to FAULT.
  - An ack in the same cycle the counter reaches TIMEOUT wins; no fault is raised.
- FAULT: fault=1, all request and strobe outputs 0, pc and ir frozen. Only rst exits FAULT.
- run deasserted mid-instruction: the current instruction completes; run is sampled only at the end of DECODE-NOP, STORE-ack and WB.
- Request signals hold steady until ack; the address does not change while imem_req is high.
- retired: 32-bit counter, wraps at 2^32.
- rf_we and dmem_req are never high in the same cycle.

Decomposition:
- Package mcycle_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
  - opcode localparams: OP_NOP, OP_LOAD, OP_STORE.
  - DWIDTH and AWIDTH defaults.
- Sub-module mem_wait_timer: 8-bit wait counter with clear, enable and expired output. Instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset, then run=1 with zero-wait memory and an ALU instruction (bit31=0, op 0000) at addr 0 -> imem_req in cycle 1, alu_en in cycle 3, rf_we in cycle 4; pc=1 and retired=1 afterwards.
- LOAD (op 0100) with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0, then rf_we pulses once; retired increments by 1.
- STORE (op 0110) -> dmem_req=1 with dmem_we=1, rf_we stays 0; next imem_addr = previous pc+1.
- NOP stream of 3 instructions -> each takes 2 cycles, alu_en and rf_we stay 0, retired=3.
- imem_ack withheld for TIMEOUT+1 cycles -> fault=1, busy=0, imem_req=0 and held until rst; repeat with ack arriving exactly on the TIMEOUT cycle -> no fault.
- Preload pc=16'hFFFF via a fetch sequence, then fetch once -> pc wraps to 0. Assert rst during MEM -> next cycle state=IDLE with all outputs at their reset values.

Source files
------------

// File: rtl/mcycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle sequencer: FSM states,
// fixed opcode encodings and default widths.
package mcycle_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 16;
  localparam int WAIT_BITS  = 8;

  localparam logic [3:0] OP_NOP   = 4'b1111;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0110;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    FAULT
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mcycle_sequencer_if.sv
// Bundle of the sequencer's memory handshakes, datapath strobes and status.
// master = sequencer side, slave = memories / surrounding datapath.
interface mcycle_sequencer_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 16
);

  logic              run;
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_ack;
  logic [DWIDTH-1:0] imem_rdata;
  logic [DWIDTH-1:0] ir;
  logic [AWIDTH-1:0] pc;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic              alu_en;
  logic              rf_we;
  logic              busy;
  logic              fault;
  logic [31:0]       retired;

  modport master (
    input  run, imem_ack, imem_rdata, dmem_ack,
    output imem_req, imem_addr, ir, pc, dmem_req, dmem_we,
           alu_en, rf_we, busy, fault, retired
  );

  modport slave (
    output run, imem_ack, imem_rdata, dmem_ack,
    input  imem_req, imem_addr, ir, pc, dmem_req, dmem_we,
           alu_en, rf_we, busy, fault, retired
  );

endinterface

// File: rtl/mcycle_sequencer_mem_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access; it
// saturates at TIMEOUT and flags expiry while the request is still pending.
module mem_wait_timer
  import mcycle_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WAIT_BITS-1:0] LIMIT = WAIT_BITS'(TIMEOUT);

  logic [WAIT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + WAIT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/mcycle_sequencer.sv
// Multi-cycle control FSM: fetches into the IR, steps DECODE/EXEC/MEM/WB,
// pulses ALU/register-file strobes and traps memory timeouts into FAULT.
module mcycle_sequencer
  import mcycle_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  mcycle_sequencer_if.master bus
);

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [31:0]       retired_q, retired_d;

  logic       imem_req, dmem_req, dmem_we, alu_en, rf_we;
  logic       wait_active, wait_ack, wait_expired;
  logic [3:0] opcode;

  assign opcode = ir_q[18:15];

  // The counter runs only while a request is outstanding, so it is already
  // zero whenever FETCH or MEM is entered, including MEM -> FETCH back to back.
  assign wait_active = (state_q == FETCH) || (state_q == MEM);
  assign wait_ack    = (state_q == FETCH) ? bus.imem_ack : bus.dmem_ack;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!wait_active || wait_ack),
    .en_i     (wait_active && !wait_ack),
    .expired_o(wait_expired)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + AWIDTH'(1);
          state_d = DECODE;
        end else if (wait_expired) begin
          state_d = FAULT;
        end
      end
      DECODE: begin
        if (opcode == OP_NOP) begin
          retired_d = retired_q + 32'd1;
          state_d   = bus.run ? FETCH : IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_en  = 1'b1;
        state_d = is_mem_op(opcode) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (bus.dmem_ack) begin
          if (opcode == OP_STORE) begin
            retired_d = retired_q + 32'd1;
            state_d   = bus.run ? FETCH : IDLE;
          end else begin
            state_d = WB;
          end
        end else if (wait_expired) begin
          state_d = FAULT;
        end
      end
      WB: begin
        rf_we     = 1'b1;
        retired_d = retired_q + 32'd1;
        state_d   = bus.run ? FETCH : IDLE;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.pc        = pc_q;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.alu_en    = alu_en;
  assign bus.rf_we     = rf_we;
  assign bus.busy      = (state_q != IDLE) && (state_q != FAULT);
  assign bus.fault     = (state_q == FAULT);
  assign bus.retired   = retired_q;

endmodule
